// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment formatter.
// Holds the blank/dash patterns, the decimal range limit, the FSM state
// encoding and the hex/decimal digit code table. Patterns are active-low
// {a,b,c,d,e,f,g,dp}, so bit 0 is the decimal point.
package seg_pkg;

  localparam logic [7:0]  SEG_BLANK = 8'hFF;
  localparam logic [7:0]  SEG_DASH  = 8'hFD;
  localparam logic [31:0] DEC_MAX   = 32'd99_999_999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  // Digit code table 0..F; the dp bit is 1 (off) in every entry.
  function automatic logic [7:0] seg_code(input logic [3:0] digit);
    logic [7:0] code;
    case (digit)
      4'h0: code = 8'h03;
      4'h1: code = 8'h9F;
      4'h2: code = 8'h25;
      4'h3: code = 8'h0D;
      4'h4: code = 8'h99;
      4'h5: code = 8'h49;
      4'h6: code = 8'h41;
      4'h7: code = 8'h1F;
      4'h8: code = 8'h01;
      4'h9: code = 8'h09;
      4'hA: code = 8'h11;
      4'hB: code = 8'hC1;
      4'hC: code = 8'h63;
      4'hD: code = 8'h85;
      4'hE: code = 8'h61;
      default: code = 8'h71;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg_digit_encode.sv
// Single-digit pattern encoder.
// Ports:
//   digit   in  4  digit value 0..F
//   blank   in  1  1: force all segments dark (dp included)
//   dp      in  1  1: light the decimal point on a shown digit
//   pattern out 8  active-low {a,b,c,d,e,f,g,dp}
module seg_digit_encode
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] pattern
);

  logic [7:0] code;

  always_comb begin
    code    = seg_code(digit);
    pattern = SEG_BLANK;
    if (!blank) begin
      pattern = {code[7:1], ~dp};
    end
  end

endmodule

// File: rtl/seg_format.sv
// Seven-segment formatter: turns a 32-bit value into eight registered
// active-low digit patterns (num0 = rightmost). Hex mode encodes nibbles
// directly; decimal mode runs a 32-cycle shift/add-3 conversion.
// Optional build macro: SEG_DP_EN adds the dpMask port and per-digit
// decimal points; without it every dp bit stays 1.
// Ports:
//   cp        in  1   clock
//   rst       in  1   synchronous active-high reset
//   start     in  1   conversion request, taken only when idle
//   value     in  32  number to display, captured with start
//   hexMode   in  1   1: hex, 0: decimal, captured with start
//   dpMask    in  8   per-digit dp enable (SEG_DP_EN only)
//   busy      out 1   conversion in progress
//   done      out 1   one-cycle pulse when num0..num7 update
//   ovf       out 1   last decimal request was above 99_999_999
//   num0..7   out 8   digit patterns
module seg_format
  import seg_pkg::*;
#(
  parameter int BLANK_LZ = 1
) (
  input  logic        cp,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  input  logic        hexMode,
`ifdef SEG_DP_EN
  input  logic [7:0]  dpMask,
`endif
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [7:0]  num0,
  output logic [7:0]  num1,
  output logic [7:0]  num2,
  output logic [7:0]  num3,
  output logic [7:0]  num4,
  output logic [7:0]  num5,
  output logic [7:0]  num6,
  output logic [7:0]  num7
);

  state_t      state, state_nxt;
  logic        take;
  logic        ovf_req;
  logic [31:0] sr_p0;
  logic [31:0] bcd_p0;
  logic [31:0] bcd_adj;
  logic [4:0]  cnt_p0;
  logic        hex_p0;
  logic        ovf_p0;
  logic [7:0]  dp_en;
  logic [3:0]  dig   [8];
  logic        blank [8];
  logic [7:0]  enc   [8];
  logic [7:0]  pat   [8];
  logic [7:0]  num_r [8];

  assign take    = (state == IDLE) && start;
  assign ovf_req = !hexMode && (value > DEC_MAX);

  // FSM state register
  always_ff @(posedge cp) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (hexMode || ovf_req) ? LOAD : CONV;
      CONV: if (cnt_p0 == 5'd31) state_nxt = LOAD;
      LOAD: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state != IDLE);
  end

  // Each BCD digit >= 5 gets +3 before the shift; 5..9 + 3 stays within 4 bits.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      bcd_adj[4*i +: 4] = (bcd_p0[4*i +: 4] >= 4'd5) ? bcd_p0[4*i +: 4] + 4'd3
                                                     : bcd_p0[4*i +: 4];
    end
  end

  // Stage p0: request capture and shift/add-3 iteration
  always_ff @(posedge cp) begin
    if (take) begin
      sr_p0  <= value;
      bcd_p0 <= '0;
      cnt_p0 <= '0;
      hex_p0 <= hexMode;
      ovf_p0 <= ovf_req;
    end else if (state == CONV) begin
      bcd_p0 <= {bcd_adj[30:0], sr_p0[31]};
      sr_p0  <= {sr_p0[30:0], 1'b0};
      cnt_p0 <= cnt_p0 + 5'd1;
    end
  end

`ifdef SEG_DP_EN
  logic [7:0] dp_p0;
  always_ff @(posedge cp) begin
    if (take) dp_p0 <= dpMask;
  end
  assign dp_en = dp_p0;
`else
  assign dp_en = '0;
`endif

  // Leading-zero blanking walks down from the top digit; num0 is never blanked.
  always_comb begin
    logic seen;
    seen = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      dig[i] = hex_p0 ? sr_p0[4*i +: 4] : bcd_p0[4*i +: 4];
      seen   = seen || (dig[i] != 4'd0);
      blank[i] = (BLANK_LZ != 0) && (i != 0) && !seen;
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_enc
    seg_digit_encode u_enc (
      .digit   (dig[g]),
      .blank   (blank[g]),
      .dp      (dp_en[g]),
      .pattern (enc[g])
    );
  end

  // Overflow shows dashes on every digit, never blanked.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pat[i] = ovf_p0 ? {SEG_DASH[7:1], ~dp_en[i]} : enc[i];
    end
  end

  // Stage p1: output registers, updated only on the done edge
  always_ff @(posedge cp) begin
    if (rst) begin
      done <= 1'b0;
      ovf  <= 1'b0;
      for (int i = 0; i < 8; i++) num_r[i] <= SEG_BLANK;
    end else begin
      done <= (state == LOAD);
      if (state == LOAD) begin
        ovf <= ovf_p0;
        for (int i = 0; i < 8; i++) num_r[i] <= pat[i];
      end
    end
  end

  assign num0 = num_r[0];
  assign num1 = num_r[1];
  assign num2 = num_r[2];
  assign num3 = num_r[3];
  assign num4 = num_r[4];
  assign num5 = num_r[5];
  assign num6 = num_r[6];
  assign num7 = num_r[7];

endmodule

// File: tb/tb_seg_format.sv
// Directed bench for seg_format: one instance with leading-zero blanking,
// one without, driven from shared inputs.
module tb_seg_format;

  logic        cp = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic        hexMode;
  logic [7:0]  dpMask;
  logic        busy, done, ovf;
  logic [7:0]  n0, n1, n2, n3, n4, n5, n6, n7;
  logic        busy_b, done_b, ovf_b;
  logic [7:0]  m0, m1, m2, m3, m4, m5, m6, m7;

  int tests = 0;
  int fails = 0;

  always #5 cp = ~cp;

  seg_format #(.BLANK_LZ(1)) dut (
    .cp(cp), .rst(rst), .start(start), .value(value), .hexMode(hexMode),
`ifdef SEG_DP_EN
    .dpMask(dpMask),
`endif
    .busy(busy), .done(done), .ovf(ovf),
    .num0(n0), .num1(n1), .num2(n2), .num3(n3),
    .num4(n4), .num5(n5), .num6(n6), .num7(n7)
  );

  seg_format #(.BLANK_LZ(0)) dut_nb (
    .cp(cp), .rst(rst), .start(start), .value(value), .hexMode(hexMode),
`ifdef SEG_DP_EN
    .dpMask(dpMask),
`endif
    .busy(busy_b), .done(done_b), .ovf(ovf_b),
    .num0(m0), .num1(m1), .num2(m2), .num3(m3),
    .num4(m4), .num5(m5), .num6(m6), .num7(m7)
  );

  wire [63:0] nums   = {n7, n6, n5, n4, n3, n2, n1, n0};
  wire [63:0] nums_b = {m7, m6, m5, m4, m3, m2, m1, m0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request so that the next rising edge is E0; returns at E0+1.
  task automatic do_start(input logic [31:0] v, input logic hx);
    @(negedge cp);
    value   = v;
    hexMode = hx;
    start   = 1'b1;
    @(posedge cp);
    #1;
    start = 1'b0;
  endtask

  // Edges from E0 until done is seen; 0 means the 100-cycle bound expired.
  task automatic wait_done(output int n);
    int k;
    logic seen;
    n = 0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 100) begin
      @(posedge cp);
      #1;
      k++;
      if (done) begin
        seen = 1'b1;
        n = k;
      end
    end
  endtask

  initial begin
    int n;
    int ndone;
    int done_at;
    logic bad;
    logic [63:0] cap;

    rst = 1'b1; start = 1'b0; value = '0; hexMode = 1'b0; dpMask = '0;
    repeat (3) @(posedge cp);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_ovf",  {63'd0, ovf},  64'd0);
    chk("rst_nums", nums, {8{8'hFF}});
    @(negedge cp);
    rst = 1'b0;

    // Hex 1234ABCD: one-cycle latency.
    do_start(32'h1234ABCD, 1'b1);
    chk("hex_busy_e0", {63'd0, busy}, 64'd1);
    wait_done(n);
    chk("hex_latency", 64'(n), 64'd1);
    chk("hex_busy_e1", {63'd0, busy}, 64'd0);
    chk("hex_nums", nums, 64'h9F250D9911C16385);
    @(posedge cp); #1;
    chk("hex_done_pulse", {63'd0, done}, 64'd0);
    chk("hex_nums_hold", nums, 64'h9F250D9911C16385);

    // Decimal 12345678: busy through E32, done only at E33.
    do_start(32'd12345678, 1'b0);
    bad = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(posedge cp); #1;
      if (!busy || done) bad = 1'b1;
      if (nums !== 64'h9F250D9911C16385) bad = 1'b1;
    end
    chk("dec_busy_hold", {63'd0, bad}, 64'd0);
    @(posedge cp); #1;
    chk("dec_done_e33", {62'd0, done, busy}, 64'd2);
    chk("dec_nums", nums, 64'h9F250D9949411F01);
    chk("dec_ovf", {63'd0, ovf}, 64'd0);

    // Overflow then a small decimal value clears it.
    do_start(32'd100000000, 1'b0);
    wait_done(n);
    chk("ovf_latency", 64'(n), 64'd1);
    chk("ovf_flag", {63'd0, ovf}, 64'd1);
    chk("ovf_dash", nums, {8{8'hFD}});
    chk("ovf_dash_nb", nums_b, {8{8'hFD}});
    do_start(32'd7, 1'b0);
    wait_done(n);
    chk("dec7_latency", 64'(n), 64'd33);
    chk("dec7_ovf", {63'd0, ovf}, 64'd0);
    chk("dec7_nums", nums, 64'hFFFFFFFFFFFFFF1F);
    chk("dec7_nums_nb", nums_b, 64'h030303030303031F);

    // Hex zero: blanking vs. all digits shown.
    do_start(32'h0, 1'b1);
    wait_done(n);
    chk("hex0_nums", nums, 64'hFFFFFFFFFFFFFF03);
    chk("hex0_nums_nb", nums_b, {8{8'h03}});

    // Max decimal with a second start at E5 that must be ignored.
    do_start(32'd99999999, 1'b0);
    ndone = 0; done_at = 0; cap = '0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        value = 32'h5; hexMode = 1'b1; start = 1'b1;
      end
      @(posedge cp); #1;
      start = 1'b0;
      if (done) begin
        ndone++;
        done_at = k;
        cap = nums;
      end
    end
    chk("ign_done_count", 64'(ndone), 64'd1);
    chk("ign_done_at", 64'(done_at), 64'd33);
    chk("ign_nums", cap, {8{8'h09}});

    // Reset at E10 of a conversion.
    do_start(32'd12345678, 1'b0);
    repeat (9) @(posedge cp);
    #1;
    rst = 1'b1;
    @(posedge cp); #1;
    rst = 1'b0;
    chk("midrst_state", {61'd0, busy, done, ovf}, 64'd0);
    chk("midrst_nums", nums, {8{8'hFF}});
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge cp); #1;
      if (done) ndone++;
    end
    chk("midrst_no_done", 64'(ndone), 64'd0);

`ifdef SEG_DP_EN
    dpMask = 8'h01;
    do_start(32'h5, 1'b1);
    wait_done(n);
    chk("dp_nums", nums, 64'hFFFFFFFFFFFFFF48);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
